// File: rtl/fnd_display_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fnd_display_arbiter_pkg
// Description : Shared definitions for the FND display arbiter and the blocks
//               around it: the arbiter state encoding, the default hold-tick
//               divider and the value width used by the FND controller.
// Revision    : 1.0 - initial release
// ============================================================================
package fnd_display_arbiter_pkg;

    // Width of one displayed value; identical to the FND controller input.
    localparam int FND_VAL_W = 9;

    // clk cycles per 1 kHz hold tick at 100 MHz.
    localparam int FND_TICK_DIV = 100_000;

    // Arbiter state encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_OPEN = 2'd2
    } arb_state_t;

endpackage : fnd_display_arbiter_pkg
`default_nettype wire

// File: rtl/fnd_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : fnd_tick_gen
// Description : Free-running divider that emits a one-cycle pulse every
//               TICK_DIV clk cycles after reset release. Shared with the FND
//               digit scanner.
// Ports       : clk     - system clock
//               reset_n - asynchronous reset, active low
//               o_tick  - one-cycle pulse every TICK_DIV clks
// Revision    : 1.0 - initial release
// ============================================================================
module fnd_tick_gen
    import fnd_display_arbiter_pkg::*;
#(
    parameter int TICK_DIV = FND_TICK_DIV
) (
    input  logic clk,
    input  logic reset_n,
    output logic o_tick
);

    localparam int             c_CW   = $clog2(TICK_DIV);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(TICK_DIV - 1);

    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CW'(1);
        end
    end

    // The pulse is consumed on the TICK_DIV-th edge after reset release.
    assign o_tick = (r_cnt == c_LAST);

endmodule : fnd_tick_gen
`default_nettype wire

// File: rtl/fnd_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fnd_display_arbiter
// Description : Time-shares the 4-digit FND display between N_REQ requesters.
//               Round-robin grant with a minimum on-screen hold time counted
//               in hold ticks; after the hold expires the owner keeps the
//               display until it drops or another requester asks.
// Ports       : clk      - system clock
//               reset_n  - asynchronous reset, active low
//               req      - per-requester level request
//               value    - packed values, requester i at [i*VAL_W +: VAL_W]
//               grant    - registered one-hot owner, zero when idle
//               o_owner  - index of current owner, 0 when idle
//               o_valid  - high while a grant is active
//               o_value  - live value of the owner, 0 when idle
// Revision    : 1.0 - initial release
// ============================================================================
module fnd_display_arbiter
    import fnd_display_arbiter_pkg::*;
#(
    parameter int N_REQ      = 3,
    parameter int VAL_W      = FND_VAL_W,
    parameter int TICK_DIV   = FND_TICK_DIV,
    parameter int HOLD_TICKS = 2000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*VAL_W-1:0] value,
    output logic [N_REQ-1:0]       grant,
    output logic [1:0]             o_owner,
    output logic                   o_valid,
    output logic [VAL_W-1:0]       o_value
);

    localparam int               c_TW        = $clog2(HOLD_TICKS + 1);
    localparam logic [c_TW-1:0]  c_HOLD      = c_TW'(HOLD_TICKS);
    localparam logic [c_TW-1:0]  c_TIMER_ONE = c_TW'(1);
    localparam logic [1:0]       c_LAST_INIT = 2'(N_REQ - 1);
    localparam logic [N_REQ-1:0] c_ONE       = N_REQ'(1);

    arb_state_t       r_state;
    arb_state_t       w_next_state;
    logic [N_REQ-1:0] r_grant;
    logic [1:0]       r_owner;
    logic [1:0]       r_last;
    logic [c_TW-1:0]  r_timer;

    logic             w_tick;
    logic             w_owner_req;
    logic [2:0]       w_rr_all;
    logic [2:0]       w_rr_other;
    logic             w_issue;
    logic [1:0]       w_pick;

    fnd_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .o_tick  (w_tick)
    );

    // Returns {found, index}: first set bit of cand searching upward from
    // last+1 with wrap. Iterating farthest-first lets the nearest hit win.
    function automatic logic [2:0] rr_pick(input logic [N_REQ-1:0] cand,
                                           input logic [1:0]       last);
        logic [2:0] res;
        int         idx;
        res = 3'b000;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % N_REQ;
            if (cand[idx]) begin
                res = {1'b1, idx[1:0]};
            end
        end
        return res;
    endfunction

    assign w_owner_req = |(req & r_grant);
    assign w_rr_all    = rr_pick(req, r_last);
    assign w_rr_other  = rr_pick(req & ~r_grant, r_owner);

    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_pick       = r_owner;
        case (r_state)
            ST_IDLE: begin
                if (w_rr_all[2]) begin
                    w_issue      = 1'b1;
                    w_pick       = w_rr_all[1:0];
                    w_next_state = ST_HOLD;
                end
            end
            ST_HOLD, ST_OPEN: begin
                if (!w_owner_req) begin
                    // Release has priority over a coincident hold expiry.
                    if (w_rr_all[2]) begin
                        w_issue      = 1'b1;
                        w_pick       = w_rr_all[1:0];
                        w_next_state = ST_HOLD;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end else if (r_state == ST_HOLD) begin
                    if (w_tick && (r_timer == c_TIMER_ONE)) begin
                        w_next_state = ST_OPEN;
                    end
                end else if (w_rr_other[2]) begin
                    w_issue      = 1'b1;
                    w_pick       = w_rr_other[1:0];
                    w_next_state = ST_HOLD;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_owner <= 2'd0;
            r_last  <= c_LAST_INIT;
            r_timer <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_issue) begin
                r_grant <= c_ONE << w_pick;
                r_owner <= w_pick;
                r_last  <= w_pick;
                r_timer <= c_HOLD;
            end else if (w_next_state == ST_IDLE) begin
                r_grant <= '0;
                r_owner <= 2'd0;
                r_timer <= '0;
            end else if ((r_state == ST_HOLD) && w_tick && (r_timer != '0)) begin
                r_timer <= r_timer - c_TIMER_ONE;
            end
        end
    end

    assign grant   = r_grant;
    assign o_owner = r_owner;
    assign o_valid = (r_state != ST_IDLE);
    assign o_value = o_valid ? value[r_owner*VAL_W +: VAL_W] : '0;

endmodule : fnd_display_arbiter
`default_nettype wire

// File: tb/tb_fnd_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fnd_display_arbiter
// Description : Self-checking bench for fnd_display_arbiter with
//               TICK_DIV=10 and HOLD_TICKS=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fnd_display_arbiter;

    localparam int N_REQ      = 3;
    localparam int VAL_W      = 9;
    localparam int TICK_DIV   = 10;
    localparam int HOLD_TICKS = 4;

    // Hold window: grant edge to next grant edge when the hold expires into
    // OPEN and another requester then takes over (4 ticks + 1 OPEN cycle).
    localparam int c_WIN_LO = 3 * TICK_DIV + 2;
    localparam int c_WIN_HI = 4 * TICK_DIV + 1;

    logic                   clk;
    logic                   reset_n;
    logic [N_REQ-1:0]       req;
    logic [VAL_W-1:0]       v0, v1, v2;
    logic [N_REQ*VAL_W-1:0] value;
    logic [N_REQ-1:0]       grant;
    logic [1:0]             o_owner;
    logic                   o_valid;
    logic [VAL_W-1:0]       o_value;

    assign value = {v2, v1, v0};

    fnd_display_arbiter #(
        .N_REQ      (N_REQ),
        .VAL_W      (VAL_W),
        .TICK_DIV   (TICK_DIV),
        .HOLD_TICKS (HOLD_TICKS)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .value   (value),
        .grant   (grant),
        .o_owner (o_owner),
        .o_valid (o_valid),
        .o_value (o_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0] req;
        logic [8:0] v0, v1, v2;
        logic [2:0] grant;
        logic [1:0] owner;
        logic       valid;
        logic [8:0] oval;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = 3'b000;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Counts edges until grant changes, bounded at 100.
    task automatic wait_change(output int n);
        logic [2:0] prev;
        prev = grant;
        n    = 0;
        while (grant == prev && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int ticks;
        int guard;

        //          req     v0  v1   v2   grant  own valid oval
        vecs[0]  = '{3'b000, 7, 123, 300, 3'b000, 0, 0,   0};
        vecs[1]  = '{3'b010, 7, 123, 300, 3'b010, 1, 1, 123};
        vecs[2]  = '{3'b010, 7,  45, 300, 3'b010, 1, 1,  45};
        vecs[3]  = '{3'b011, 7,  45, 300, 3'b010, 1, 1,  45};
        vecs[4]  = '{3'b001, 7,  45, 300, 3'b001, 0, 1,   7};
        vecs[5]  = '{3'b101, 9,  45, 300, 3'b001, 0, 1,   9};
        vecs[6]  = '{3'b100, 9,  45, 300, 3'b100, 2, 1, 300};
        vecs[7]  = '{3'b111, 9,  45, 511, 3'b100, 2, 1, 511};
        vecs[8]  = '{3'b011, 9,  45, 511, 3'b001, 0, 1,   9};
        vecs[9]  = '{3'b000, 9,  45, 511, 3'b000, 0, 0,   0};
        vecs[10] = '{3'b111, 9,  45, 511, 3'b010, 1, 1,  45};
        vecs[11] = '{3'b000, 9,  45, 511, 3'b000, 0, 0,   0};
        vecs[12] = '{3'b100, 9,  45, 256, 3'b100, 2, 1, 256};
        vecs[13] = '{3'b000, 9,  45, 256, 3'b000, 0, 0,   0};

        reset_n = 1'b0;
        req     = 3'b111;
        v0 = 9'd7; v1 = 9'd123; v2 = 9'd300;

        // 1: reset with all requests high, then first pick is index 0
        repeat (3) @(negedge clk);
        chk("rst_grant", int'(grant), 0);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_value", int'(o_value), 0);
        chk("rst_owner", int'(o_owner), 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("first_grant", int'(grant), 1);
        chk("first_owner", int'(o_owner), 0);

        // 6: async reset mid-HOLD with owner 2
        req = 3'b100;
        @(negedge clk);
        chk("pre_arst_grant", int'(grant), 4);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_grant", int'(grant), 0);
        chk("arst_valid", int'(o_valid), 0);
        chk("arst_value", int'(o_value), 0);
        req = 3'b111;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_arst_grant", int'(grant), 1);

        // Table: picks, releases and ignored requests, all inside one hold
        do_reset();
        for (int i = 0; i < 14; i++) begin
            req = vecs[i].req;
            v0  = vecs[i].v0;
            v1  = vecs[i].v1;
            v2  = vecs[i].v2;
            @(negedge clk);
            n_tests++;
            if (grant !== vecs[i].grant || o_owner !== vecs[i].owner ||
                o_valid !== vecs[i].valid || o_value !== vecs[i].oval) begin
                n_fail++;
                $display("FAIL vec%0d: got g=%b own=%0d v=%b val=%0d expected g=%b own=%0d v=%b val=%0d",
                         i, grant, o_owner, o_valid, o_value,
                         vecs[i].grant, vecs[i].owner, vecs[i].valid, vecs[i].oval);
            end
        end

        // 2: single requester reaches OPEN and keeps the display
        do_reset();
        v1  = 9'd123;
        req = 3'b010;
        @(negedge clk);
        chk("t2_grant", int'(grant), 2);
        chk("t2_value", int'(o_value), 123);
        repeat (45) @(negedge clk);
        chk("t2_open_grant", int'(grant), 2);
        v1 = 9'd45;
        #1;
        chk("t2_live_value", int'(o_value), 45);
        req = 3'b011;
        @(negedge clk);
        chk("t2_open_handoff", int'(grant), 1);

        // 3: two requesters alternate after each full hold
        do_reset();
        v0 = 9'd7; v2 = 9'd300;
        req = 3'b101;
        @(negedge clk);
        chk("t3_grant0", int'(grant), 1);
        chk("t3_value0", int'(o_value), 7);
        wait_change(n);
        chk_range("t3_hold0", n, c_WIN_LO, c_WIN_HI);
        chk("t3_grant2", int'(grant), 4);
        chk("t3_value2", int'(o_value), 300);
        wait_change(n);
        chk_range("t3_hold2", n, c_WIN_LO, c_WIN_HI);
        chk("t3_grant0b", int'(grant), 1);

        // 4: release mid-hold hands over and reloads the timer
        do_reset();
        req = 3'b001;
        @(negedge clk);
        chk("t4_grant0", int'(grant), 1);
        repeat (12) @(negedge clk);
        req = 3'b010;
        @(negedge clk);
        chk("t4_grant1", int'(grant), 2);
        req = 3'b011;
        wait_change(n);
        chk_range("t4_reload", n, c_WIN_LO, c_WIN_HI);
        chk("t4_grant0b", int'(grant), 1);
        req = 3'b000;
        @(negedge clk);
        chk("t4_idle_grant", int'(grant), 0);
        chk("t4_idle_valid", int'(o_valid), 0);
        chk("t4_idle_value", int'(o_value), 0);

        // 5: owner drops on the very cycle the last hold tick fires
        do_reset();
        req = 3'b101;
        @(negedge clk);
        chk("t5_grant0", int'(grant), 1);
        ticks = 0;
        guard = 0;
        while (ticks < HOLD_TICKS && guard < 100) begin
            if (dut.u_tick_gen.o_tick === 1'b1) ticks++;
            if (ticks < HOLD_TICKS) begin
                @(negedge clk);
                guard++;
            end
        end
        chk("t5_ticks_seen", ticks, HOLD_TICKS);
        req = 3'b100;
        @(negedge clk);
        chk("t5_release_grant", int'(grant), 4);
        req = 3'b101;
        wait_change(n);
        chk_range("t5_hold_reloaded", n, c_WIN_LO, c_WIN_HI);
        chk("t5_grant0b", int'(grant), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fnd_display_arbiter
`default_nettype wire
